// File: rtl/gem_fiber_in.sv
// GEM trigger-fiber receive decoder: frames K-lane words into BX records, tracks lock and latency markers.
// Optional saturating error counter is built when GEM_RX_ERR_CNT_EN is defined; otherwise err_cnt reads 0.
module gem_fiber_in #(
    parameter int LOCK_FRAMES   = 16,
    parameter int UNLOCK_ERRORS = 4,
    parameter int MARKER_PERIOD = 128,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     clk_80,
    input  logic                     reset_n,
    input  logic [31:0]              rx_data,
    input  logic [3:0]               rx_isk,
    input  logic [3:0]               rx_err,
    input  logic                     rx_ready,
    output logic [13:0]              cluster0,
    output logic [13:0]              cluster1,
    output logic [13:0]              cluster2,
    output logic [13:0]              cluster3,
    output logic                     overflow,
    output logic                     valid,
    output logic                     bx0,
    output logic                     locked,
    output logic                     marker_err,
    output logic                     frame_err,
    input  logic                     err_cnt_clr,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt
);

    localparam int BXW = $clog2(MARKER_PERIOD);
    localparam int GCW = $clog2(LOCK_FRAMES + 1);
    localparam int BCW = $clog2(UNLOCK_ERRORS + 1);
    localparam logic [BXW-1:0] BX_LAST   = BXW'(MARKER_PERIOD - 1);
    localparam logic [GCW-1:0] GOOD_LAST = GCW'(LOCK_FRAMES - 1);
    localparam logic [BCW-1:0] BAD_LAST  = BCW'(UNLOCK_ERRORS - 1);

    localparam logic [7:0] K_NORM     = 8'hBC;
    localparam logic [7:0] K_NORM_OVF = 8'hF7;
    localparam logic [7:0] K_MARK     = 8'hFC;
    localparam logic [7:0] K_MARK_OVF = 8'hFD;

    typedef enum logic [1:0] {
        S_HUNT,
        S_CHECK,
        S_LOCKED
    } state_t;

    state_t           r_state;
    logic [GCW-1:0]   r_good_cnt;
    logic [BCW-1:0]   r_bad_cnt;
    logic [BXW-1:0]   r_bx_cnt;
    logic             r_phase_b;
    logic             r_a_bad;
    logic             r_a_marker;
    logic             r_a_ovf;
    logic [23:0]      r_a_data;
    logic [55:0]      r_cluster;
    logic             r_overflow;
    logic             r_valid;
    logic             r_bx0;
    logic             r_locked;
    logic             r_marker_err;
    logic             r_frame_err;

    logic             w_k_legal;
    logic             w_k_marker;
    logic             w_k_ovf;
    logic             w_k_word;
    logic             w_force_a;
    logic             w_slot_b;
    logic             w_frame_end;
    logic             w_frame_good;
    logic             w_bx_wrap;
    logic             w_marker_err_set;
    logic             w_frame_err_set;
    logic [55:0]      w_data;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_k_legal  = 1'b0;
        w_k_marker = 1'b0;
        w_k_ovf    = 1'b0;
        case (rx_data[7:0])
            K_NORM:     w_k_legal = 1'b1;
            K_NORM_OVF: begin w_k_legal = 1'b1; w_k_ovf = 1'b1; end
            K_MARK:     begin w_k_legal = 1'b1; w_k_marker = 1'b1; end
            K_MARK_OVF: begin w_k_legal = 1'b1; w_k_marker = 1'b1; w_k_ovf = 1'b1; end
            default:    ;
        endcase
    end

    // While hunting, a legal K word re-anchors the phase to word A.
    assign w_k_word     = (rx_isk == 4'b0001) && w_k_legal;
    assign w_force_a    = (r_state == S_HUNT) && w_k_word;
    assign w_slot_b     = r_phase_b && !w_force_a;
    assign w_frame_end  = w_slot_b && rx_ready;
    assign w_frame_good = !r_a_bad && (rx_err == 4'h0) && (rx_isk == 4'h0);
    assign w_data       = {rx_data, r_a_data};
    assign w_bx_wrap    = (r_bx_cnt == BX_LAST);

    assign w_marker_err_set = w_frame_end && w_frame_good && (r_state == S_LOCKED) &&
                              (r_a_marker ? !w_bx_wrap : w_bx_wrap);
    assign w_frame_err_set  = w_frame_end && !w_frame_good && (r_state != S_HUNT);

    always_ff @(posedge clk_80 or negedge reset_n) begin
        if (!reset_n) begin
            r_phase_b  <= 1'b0;
            r_a_bad    <= 1'b1;
            r_a_marker <= 1'b0;
            r_a_ovf    <= 1'b0;
        end else begin
            r_phase_b <= !w_slot_b;
            if (!w_slot_b) begin
                r_a_bad    <= !w_k_word || (rx_err != 4'h0) || !rx_ready;
                r_a_marker <= w_k_marker;
                r_a_ovf    <= w_k_ovf;
            end
        end
    end

    // NOTE: pure datapath capture; its contents are only used once r_a_bad qualifies them, so no reset.
    always_ff @(posedge clk_80) begin
        if (!w_slot_b) begin
            r_a_data <= rx_data[31:8];
        end
    end

    always_ff @(posedge clk_80 or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_HUNT;
            r_good_cnt   <= '0;
            r_bad_cnt    <= '0;
            r_bx_cnt     <= '0;
            r_cluster    <= '1;
            r_overflow   <= 1'b0;
            r_valid      <= 1'b0;
            r_bx0        <= 1'b0;
            r_locked     <= 1'b0;
            r_marker_err <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_valid      <= 1'b0;
            r_bx0        <= 1'b0;
            r_marker_err <= w_marker_err_set;
            r_frame_err  <= w_frame_err_set;
            if (!rx_ready) begin
                r_state    <= S_HUNT;
                r_good_cnt <= '0;
                r_bad_cnt  <= '0;
                r_locked   <= 1'b0;
                r_cluster  <= '1;
                r_overflow <= 1'b0;
            end else if (w_frame_end) begin
                if (w_frame_good) begin
                    r_bx_cnt <= (r_a_marker || w_bx_wrap) ? '0 : r_bx_cnt + BXW'(1);
                    case (r_state)
                        S_HUNT: begin
                            r_state    <= S_CHECK;
                            r_good_cnt <= GCW'(1);
                        end
                        S_CHECK: begin
                            if (r_good_cnt == GOOD_LAST) begin
                                r_state    <= S_LOCKED;
                                r_locked   <= 1'b1;
                                r_good_cnt <= '0;
                            end else begin
                                r_good_cnt <= r_good_cnt + GCW'(1);
                            end
                        end
                        S_LOCKED: begin
                            r_bad_cnt  <= '0;
                            r_valid    <= 1'b1;
                            r_bx0      <= r_a_marker;
                            r_overflow <= r_a_ovf;
                            r_cluster  <= w_data;
                        end
                        default: r_state <= S_HUNT;
                    endcase
                end else begin
                    case (r_state)
                        S_CHECK: begin
                            r_state    <= S_HUNT;
                            r_good_cnt <= '0;
                        end
                        S_LOCKED: begin
                            if (r_bad_cnt == BAD_LAST) begin
                                r_state    <= S_HUNT;
                                r_locked   <= 1'b0;
                                r_bad_cnt  <= '0;
                                r_cluster  <= '1;
                                r_overflow <= 1'b0;
                            end else begin
                                r_bad_cnt <= r_bad_cnt + BCW'(1);
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign cluster0   = r_cluster[13:0];
    assign cluster1   = r_cluster[27:14];
    assign cluster2   = r_cluster[41:28];
    assign cluster3   = r_cluster[55:42];
    assign overflow   = r_overflow;
    assign valid      = r_valid;
    assign bx0        = r_bx0;
    assign locked     = r_locked;
    assign marker_err = r_marker_err;
    assign frame_err  = r_frame_err;

`ifdef GEM_RX_ERR_CNT_EN
    logic [ERR_CNT_WIDTH-1:0] r_err_cnt;
    logic [ERR_CNT_WIDTH:0]   w_err_sum;

    // One spare bit catches the carry so the count can clamp at all-ones.
    assign w_err_sum = {1'b0, r_err_cnt} + (ERR_CNT_WIDTH+1)'(w_frame_err_set)
                                         + (ERR_CNT_WIDTH+1)'(w_marker_err_set);

    always_ff @(posedge clk_80 or negedge reset_n) begin
        if (!reset_n) begin
            r_err_cnt <= '0;
        end else if (err_cnt_clr) begin
            r_err_cnt <= '0;
        end else if (w_err_sum[ERR_CNT_WIDTH]) begin
            r_err_cnt <= '1;
        end else begin
            r_err_cnt <= w_err_sum[ERR_CNT_WIDTH-1:0];
        end
    end

    assign err_cnt = r_err_cnt;
`else
    logic w_unused_clr;
    assign w_unused_clr = err_cnt_clr;
    assign err_cnt      = '0;
`endif

endmodule

// File: doc/gem_fiber_in.md
Name: gem_fiber_in

Overview:
- Receive-side decoder for the GEM fixed-latency trigger fiber.
- Consumes 8b/10b-decoded 32-bit GTX RX words at 80 MHz, two words per bunch crossing (BX).
- Frames on the K-character lane and recovers four 14-bit clusters plus the overflow flag once per BX.
- Checks the 128-BX latency marker and reports link lock and errors. Sits behind the GTX receiver at the CSC/uTCA end of each trigger link.

Parameters:
- LOCK_FRAMES, 16: consecutive good frames required to declare lock.
- UNLOCK_ERRORS, 4: consecutive bad frames that drop lock.
- MARKER_PERIOD, 128: BX between latency markers.
- ERR_CNT_WIDTH, 16: width of the saturating error counter.

Ports:
- clk_80  in  1  80 MHz RX user clock (usrclk2).
- reset_n  in  1  asynchronous, active-low reset.
- rx_data  in  32  decoded RX word; byte 0 = rx_data[7:0].
- rx_isk  in  4  per-byte K flag.
- rx_err  in  4  per-byte not-in-table OR disparity error.
- rx_ready  in  1  GTX RX reset done / PLL locked; low forces HUNT.
- cluster0..cluster3  out  14 each  recovered clusters.
- overflow  out  1  recovered overflow.
- valid  out  1  one-cycle strobe per decoded BX.
- bx0  out  1  asserted with valid on marker frames.
- locked  out  1  link locked.
- marker_err  out  1  one-cycle pulse when the marker arrives off-period.
- frame_err  out  1  one-cycle pulse per bad frame.
- err_cnt_clr  in  1  synchronous clear of err_cnt.
- err_cnt  out  ERR_CNT_WIDTH  saturating error count.

Behaviour:

Frame format:
- Word A: rx_isk=4'b0001; byte0 = K; bytes 3..1 = data[23:0].
- Word B: rx_isk=4'b0000; word = data[55:24].
- data = {cluster3, cluster2, cluster1, cluster0}.
- K code meanings:
  - 8'hBC: normal, overflow 0.
  - 8'hF7: normal, overflow 1.
  - 8'hFC: marker, overflow 0.
  - 8'hFD: marker, overflow 1.
  - Any other K code: bad frame.
- A frame is bad if any rx_err bit is set in A or B, A's K code is illegal, or B has any isk bit set.

Phase tracking:
- Phase toggles every cycle.
- In HUNT, any word with rx_isk=4'b0001 and a legal K code forces phase to A.

State machine (HUNT, CHECK, LOCKED):
- HUNT -> CHECK on the first good frame; good-frame counter = 1.
- CHECK: each good frame increments the counter. Reaching LOCK_FRAMES -> LOCKED. Any bad frame -> HUNT.
- LOCKED: each bad frame increments the bad counter; each good frame clears it. Reaching UNLOCK_ERRORS -> HUNT.
- In any state, rx_ready=0 forces HUNT on the next edge.

Outputs:
- All outputs registered. valid asserts the cycle after word B is sampled, i.e. latency 1 clk after word B (2 clks after word A).
- valid is only asserted in LOCKED and only for good frames. Bad frames in LOCKED: valid=0; clusters and overflow hold their previous values.
- When not LOCKED: clusters = 14'h3FFF, overflow = 0, valid = 0, bx0 = 0.

Marker check:
- 7-bit BX counter (log2 MARKER_PERIOD) increments on every good frame and wraps at MARKER_PERIOD-1 -> 0.
- A marker frame loads the counter to 0.
- In LOCKED, marker_err pulses if a marker arrives with counter != MARKER_PERIOD-1, or if the counter wraps without a marker. The counter then realigns to the marker.
- marker_err does not affect lock.

Reset values: all outputs 0, except cluster0..3 = 14'h3FFF. State = HUNT, counters = 0.

Simultaneous events: if rx_ready falls on the same cycle as a good word B, no valid is produced.

Optional Feature:
- Macro: GEM_RX_ERR_CNT_EN.
- Defined:
  - err_cnt increments by 1 per frame_err pulse or marker_err pulse; a coincident pair adds 2.
  - Saturates at all-ones.
  - err_cnt_clr wins over an increment on the same cycle.
  - err_cnt is held at 0 in HUNT only through reset, not through loss of lock.
- Undefined: err_cnt is tied to 0 and err_cnt_clr is ignored.

Test Plan:
- Reset, then 16 good frames of cluster0..3 = 14'h0001/0002/0003/0004 with K=BC -> locked rises after frame 16. The first valid carries exactly those values with overflow=0.
- Locked stream, one frame with K=F7 -> that BX outputs overflow=1; the next BC frame -> overflow=0.
- Marker (FC) every 128 frames -> bx0 with valid once per 128, no marker_err. Marker at frame 100 -> marker_err pulses once; next marker 128 frames later is clean.
- Locked; inject rx_err on 3 consecutive frames -> locked stays, 3 frame_err pulses, err_cnt=3. A 4th consecutive bad frame -> locked falls, clusters = 3FFF.
- Stream shifted by one word (K in odd cycle) from reset -> phase realigns in HUNT and lock is reached after 16 frames. Deassert rx_ready mid-frame -> HUNT next cycle, no valid.
- With GEM_RX_ERR_CNT_EN and ERR_CNT_WIDTH=4: 20 errors -> err_cnt=4'hF. err_cnt_clr together with an error -> 0.
